// File: rtl/cvrisc_bus_arbiter_pkg.sv
// cvrisc memory bus arbiter: shared definitions.
// Region ids, requester ids, FSM encodings and the latched request bundle.
package cvrisc_bus_arbiter_pkg;

   localparam logic [1:0] RGN_RAM  = 2'b00;
   localparam logic [1:0] RGN_MMIO = 2'b01;
   localparam logic [1:0] RGN_ROM  = 2'b10;

   localparam logic [1:0] ID_DBG = 2'd0;
   localparam logic [1:0] ID_IB  = 2'd1;
   localparam logic [1:0] ID_DB  = 2'd2;

   localparam logic [1:0] S_IDLE   = 2'd0;
   localparam logic [1:0] S_STROBE = 2'd1;
   localparam logic [1:0] S_WAIT   = 2'd2;
   localparam logic [1:0] S_ACK    = 2'd3;

   typedef struct packed {
      logic [1:0]  id;
      logic [13:0] woff;
      logic [3:0]  wren;
      logic [31:0] wdata;
   } bus_req_t;

   function automatic logic [2:0] rgn_onehot(input logic [1:0] rgn);
      logic [2:0] oh;
      case (rgn)
         RGN_RAM:  oh = 3'b001;
         RGN_MMIO: oh = 3'b010;
         RGN_ROM:  oh = 3'b100;
         default:  oh = 3'b000;
      endcase
      return oh;
   endfunction

endpackage

// File: rtl/cvrisc_bus_arbiter_addr_decode.sv
// cvrisc memory bus arbiter: address decoder.
// Maps the upper address half to a one-hot slave select.
module cvrisc_bus_arbiter_addr_decode
   import cvrisc_bus_arbiter_pkg::*;
(
   input  logic [15:0] i_adr_hi,
   output logic [2:0]  o_sel,
   output logic        o_unmapped,
   output logic        o_is_rom
);

   // Anything above 0x2ffff, or the 0x3xxxx hole, has no slave.
   assign o_unmapped = (|i_adr_hi[15:2]) | (i_adr_hi[1:0] == 2'b11);
   assign o_sel      = o_unmapped ? 3'b000 : rgn_onehot(i_adr_hi[1:0]);
   assign o_is_rom   = o_sel[2];

endmodule

// File: rtl/cvrisc_bus_arbiter.sv
// cvrisc memory bus arbiter: top.
// Debug > round-robin(ibus, dbus); one transfer in flight at a time.
module cvrisc_bus_arbiter
   import cvrisc_bus_arbiter_pkg::*;
#(
   parameter int unsigned MMIO_WAIT  = 1,
   parameter bit          DBG_ROM_WR = 1'b1
) (
   input  logic        i_clk,
   input  logic        i_n_reset,
   input  logic        i_dbg_mem_op,
   input  logic [3:0]  i_dbg_wren,
   input  logic [31:0] i_dbg_adr,
   input  logic [31:0] i_dbg_do,
   output logic [31:0] o_dbg_di,
   output logic        o_dbg_ack,
   input  logic        i_ib_req,
   input  logic [31:0] i_ib_adr,
   output logic [31:0] o_ib_rdata,
   output logic        o_ib_ack,
   output logic        o_ib_err,
   input  logic        i_db_req,
   input  logic [3:0]  i_db_we,
   input  logic [31:0] i_db_adr,
   input  logic [31:0] i_db_wdata,
   output logic [31:0] o_db_rdata,
   output logic        o_db_ack,
   output logic        o_db_err,
   output logic        o_m_en,
   output logic [2:0]  o_m_sel,
   output logic [3:0]  o_m_wren,
   output logic [15:0] o_m_adr,
   output logic [31:0] o_m_wdata,
   input  logic [31:0] i_ram_rdata,
   input  logic [31:0] i_mmio_rdata,
   input  logic [31:0] i_rom_rdata
);

   logic [1:0]  r_state;
   logic        r_rr_last_db;
   bus_req_t    r_req;
   logic [2:0]  r_sel;
   logic        r_err;
   logic [2:0]  r_cnt;
   logic [31:0] r_dbg_rd;
   logic [31:0] r_ib_rd;
   logic [31:0] r_db_rd;

   logic        w_pick_dbg;
   logic        w_pick_ib;
   logic        w_pick_db;
   logic        w_grant;
   bus_req_t    w_req;
   logic [31:2] w_adr;
   logic [2:0]  w_sel;
   logic        w_unmapped;
   logic        w_is_rom;
   logic        w_rom_wr_ok;
   logic        w_err;
   logic [31:0] w_slv_rdata;
   logic [31:0] w_rdata;
   logic        w_ack_st;

   // Mutually exclusive grant terms; rr_last_db=1 favours ibus next.
   assign w_pick_dbg = i_dbg_mem_op;
   assign w_pick_ib  = ~i_dbg_mem_op & i_ib_req
                     & (~i_db_req | r_rr_last_db);
   assign w_pick_db  = ~i_dbg_mem_op & i_db_req
                     & (~i_ib_req | ~r_rr_last_db);
   assign w_grant    = w_pick_dbg | w_pick_ib | w_pick_db;

   // Select the winning request fields; ibus is always a read.
   always_comb begin
      w_req = '0;
      w_adr = '0;
      unique case (1'b1)
         w_pick_dbg: begin
            w_req.id    = ID_DBG;
            w_adr       = i_dbg_adr[31:2];
            w_req.wren  = i_dbg_wren;
            w_req.wdata = i_dbg_do;
         end
         w_pick_ib: begin
            w_req.id = ID_IB;
            w_adr    = i_ib_adr[31:2];
         end
         w_pick_db: begin
            w_req.id    = ID_DB;
            w_adr       = i_db_adr[31:2];
            w_req.wren  = i_db_we;
            w_req.wdata = i_db_wdata;
         end
         default: ;
      endcase
      w_req.woff = w_adr[15:2];
   end

   cvrisc_bus_arbiter_addr_decode u_dec (
      .i_adr_hi   (w_adr[31:16]),
      .o_sel      (w_sel),
      .o_unmapped (w_unmapped),
      .o_is_rom   (w_is_rom)
   );

   assign w_rom_wr_ok = (w_req.id == ID_DBG) & DBG_ROM_WR;
   assign w_err = w_unmapped
                | (w_is_rom & (|w_req.wren) & ~w_rom_wr_ok);

   // Transfer sequencer, round-robin pointer and request latch.
   always_ff @(posedge i_clk or negedge i_n_reset) begin
      if (!i_n_reset) begin
         r_state      <= S_IDLE;
         r_rr_last_db <= 1'b1;
         r_req        <= '0;
         r_sel        <= '0;
         r_err        <= 1'b0;
         r_cnt        <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_grant) begin
                  r_req   <= w_req;
                  r_sel   <= w_err ? 3'b000 : w_sel;
                  r_err   <= w_err;
                  r_state <= S_STROBE;
                  if (w_pick_ib | w_pick_db)
                     r_rr_last_db <= w_pick_db;
               end
            end
            S_STROBE: begin
               if (r_sel[1] && MMIO_WAIT != 0) begin
                  r_cnt   <= 3'(MMIO_WAIT - 1);
                  r_state <= S_WAIT;
               end else begin
                  r_state <= S_ACK;
               end
            end
            S_WAIT: begin
               if (r_cnt == 3'd0)
                  r_state <= S_ACK;
               else
                  r_cnt <= r_cnt - 3'd1;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   // Response data: selected slave, forced to zero for errors and writes.
   always_comb begin
      w_slv_rdata = '0;
      unique case (1'b1)
         r_sel[0]: w_slv_rdata = i_ram_rdata;
         r_sel[1]: w_slv_rdata = i_mmio_rdata;
         r_sel[2]: w_slv_rdata = i_rom_rdata;
         default: ;
      endcase
      w_rdata = (r_err | (|r_req.wren)) ? '0 : w_slv_rdata;
   end

   // Keep each requester's last response visible until its next one.
   always_ff @(posedge i_clk or negedge i_n_reset) begin
      if (!i_n_reset) begin
         r_dbg_rd <= '0;
         r_ib_rd  <= '0;
         r_db_rd  <= '0;
      end else if (r_state == S_ACK) begin
         case (r_req.id)
            ID_DBG:  r_dbg_rd <= w_rdata;
            ID_IB:   r_ib_rd  <= w_rdata;
            ID_DB:   r_db_rd  <= w_rdata;
            default: ;
         endcase
      end
   end

   assign w_ack_st  = (r_state == S_ACK);
   assign o_dbg_ack = w_ack_st & (r_req.id == ID_DBG);
   assign o_ib_ack  = w_ack_st & (r_req.id == ID_IB) & ~r_err;
   assign o_ib_err  = w_ack_st & (r_req.id == ID_IB) & r_err;
   assign o_db_ack  = w_ack_st & (r_req.id == ID_DB) & ~r_err;
   assign o_db_err  = w_ack_st & (r_req.id == ID_DB) & r_err;

   assign o_dbg_di   = o_dbg_ack ? w_rdata : r_dbg_rd;
   assign o_ib_rdata = (o_ib_ack | o_ib_err) ? w_rdata : r_ib_rd;
   assign o_db_rdata = (o_db_ack | o_db_err) ? w_rdata : r_db_rd;

   assign o_m_en    = (r_state == S_STROBE) & ~r_err;
   assign o_m_sel   = (r_state == S_STROBE) ? r_sel : 3'b000;
   assign o_m_wren  = o_m_en ? r_req.wren : 4'h0;
   assign o_m_adr   = {r_req.woff, 2'b00};
   assign o_m_wdata = r_req.wdata;

endmodule

// File: tb/tb_cvrisc_bus_arbiter.sv
// cvrisc memory bus arbiter: self-checking bench.
// Transaction-level model plus directed scenarios with literal expectations.
module tb_cvrisc_bus_arbiter;

   localparam int W = 2;

   logic        clk = 1'b0;
   logic        n_reset;
   logic        dbg_mem_op;
   logic [3:0]  dbg_wren;
   logic [31:0] dbg_adr, dbg_do, dbg_di;
   logic        dbg_ack;
   logic        ib_req;
   logic [31:0] ib_adr, ib_rdata;
   logic        ib_ack, ib_err;
   logic        db_req;
   logic [3:0]  db_we;
   logic [31:0] db_adr, db_wdata, db_rdata;
   logic        db_ack, db_err;
   logic        m_en;
   logic [2:0]  m_sel;
   logic [3:0]  m_wren;
   logic [15:0] m_adr;
   logic [31:0] m_wdata;
   logic [31:0] ram_rdata = '0;
   logic [31:0] mmio_rdata = '0;
   logic [31:0] rom_rdata = '0;

   cvrisc_bus_arbiter #(.MMIO_WAIT(W), .DBG_ROM_WR(1'b1)) dut (
      .i_clk(clk), .i_n_reset(n_reset),
      .i_dbg_mem_op(dbg_mem_op), .i_dbg_wren(dbg_wren),
      .i_dbg_adr(dbg_adr), .i_dbg_do(dbg_do),
      .o_dbg_di(dbg_di), .o_dbg_ack(dbg_ack),
      .i_ib_req(ib_req), .i_ib_adr(ib_adr),
      .o_ib_rdata(ib_rdata), .o_ib_ack(ib_ack), .o_ib_err(ib_err),
      .i_db_req(db_req), .i_db_we(db_we), .i_db_adr(db_adr),
      .i_db_wdata(db_wdata), .o_db_rdata(db_rdata),
      .o_db_ack(db_ack), .o_db_err(db_err),
      .o_m_en(m_en), .o_m_sel(m_sel), .o_m_wren(m_wren),
      .o_m_adr(m_adr), .o_m_wdata(m_wdata),
      .i_ram_rdata(ram_rdata), .i_mmio_rdata(mmio_rdata),
      .i_rom_rdata(rom_rdata)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got=%h want=%h t=%0t", nm, act, exp, $time);
      end
   endtask

   function automatic int key_of(input logic [1:0] rg, input logic [7:0] lo);
      return int'(rg) * 64 + int'(lo[7:2]);
   endfunction

   function automatic logic [31:0] merge(input logic [31:0] old,
                                         input logic [31:0] wd,
                                         input logic [3:0] be);
      logic [31:0] r;
      r = old;
      for (int b = 0; b < 4; b++)
         if (be[b]) r[8*b +: 8] = wd[8*b +: 8];
      return r;
   endfunction

   function automatic logic [1:0] rg_of(input logic [2:0] s);
      return s[1] ? 2'd1 : (s[2] ? 2'd2 : 2'd0);
   endfunction

   // Slave memories: registered read, one-cycle latency.
   logic [31:0] smem [256] = '{default: '0};
   always @(posedge clk) begin
      if (m_en) begin
         if (m_wren != 4'h0)
            smem[key_of(rg_of(m_sel), m_adr[7:0])] <=
               merge(smem[key_of(rg_of(m_sel), m_adr[7:0])], m_wdata, m_wren);
         else begin
            if (m_sel[0]) ram_rdata  <= smem[key_of(2'd0, m_adr[7:0])];
            if (m_sel[1]) mmio_rdata <= smem[key_of(2'd1, m_adr[7:0])];
            if (m_sel[2]) rom_rdata  <= smem[key_of(2'd2, m_adr[7:0])];
         end
      end
   end

   // Transaction model: a transfer is L cycles long, strobe in its
   // first cycle and ack in its last, followed by one idle cycle.
   bit          act = 0;
   int          k = 0, m_len = 2, m_who = 0;
   logic [31:0] m_a = '0, m_wd = '0;
   logic [3:0]  m_we = '0;
   bit          m_err = 0;
   bit          rr_db = 1;
   logic [31:0] e_rd [3] = '{default: '0};
   logic [31:0] mmem [256] = '{default: '0};

   always @(posedge clk or negedge n_reset) begin : mdl
      int w;
      if (!n_reset) begin
         act = 0; k = 0; rr_db = 1;
         for (int i = 0; i < 3; i++) e_rd[i] = '0;
      end else if (act) begin
         if (k == 0 && !m_err && m_we != 4'h0)
            mmem[key_of(m_a[17:16], m_a[7:0])] =
               merge(mmem[key_of(m_a[17:16], m_a[7:0])], m_wd, m_we);
         k++;
         if (k == m_len) act = 0;
         else if (k == m_len - 1)
            e_rd[m_who] = (m_err || m_we != 4'h0) ? '0
                        : mmem[key_of(m_a[17:16], m_a[7:0])];
      end else begin
         w = -1;
         if (dbg_mem_op) w = 0;
         else if (ib_req && db_req) w = rr_db ? 1 : 2;
         else if (ib_req) w = 1;
         else if (db_req) w = 2;
         if (w >= 0) begin
            act = 1; k = 0; m_who = w;
            case (w)
               0: begin m_a = dbg_adr; m_we = dbg_wren; m_wd = dbg_do; end
               1: begin m_a = ib_adr; m_we = 4'h0; m_wd = '0; end
               default: begin m_a = db_adr; m_we = db_we; m_wd = db_wdata; end
            endcase
            if (w != 0) rr_db = (w == 2);
            m_err = (m_a[31:18] != 0) || (m_a[17:16] == 2'd3)
                 || (m_a[17:16] == 2'd2 && m_we != 4'h0 && w != 0);
            m_len = 2 + ((!m_err && m_a[17:16] == 2'd1) ? W : 0);
         end
      end
   end

   // Per-cycle comparison against the model.
   always @(negedge clk) begin : cmp
      bit sc, ac;
      sc = act && k == 0 && !m_err;
      ac = act && k == m_len - 1;
      chk("m_en", m_en, sc);
      chk("dbg_ack", dbg_ack, ac && m_who == 0);
      chk("ib_ack", ib_ack, ac && m_who == 1 && !m_err);
      chk("ib_err", ib_err, ac && m_who == 1 && m_err);
      chk("db_ack", db_ack, ac && m_who == 2 && !m_err);
      chk("db_err", db_err, ac && m_who == 2 && m_err);
      chk("dbg_di", dbg_di, e_rd[0]);
      chk("ib_rdata", ib_rdata, e_rd[1]);
      chk("db_rdata", db_rdata, e_rd[2]);
      if (sc) begin
         chk("m_sel", m_sel, 32'(3'b001 << m_a[17:16]));
         chk("m_wren", m_wren, m_we);
         chk("m_adr", m_adr, {m_a[15:2], 2'b00});
         chk("m_wdata", m_wdata, m_wd);
      end
   end

   task automatic drive(input int who, input bit on, input logic [3:0] we,
                        input logic [31:0] adr, input logic [31:0] wd);
      case (who)
         0: begin dbg_mem_op = on; dbg_wren = we; dbg_adr = adr; dbg_do = wd; end
         1: begin ib_req = on; ib_adr = adr; end
         default: begin db_req = on; db_we = we; db_adr = adr; db_wdata = wd; end
      endcase
   endtask

   task automatic drop(input int who);
      case (who)
         0: dbg_mem_op = 1'b0;
         1: ib_req = 1'b0;
         default: db_req = 1'b0;
      endcase
   endtask

   // One transfer; entered and left just after a rising edge.
   task automatic xfer(input int who, input logic [3:0] we,
                       input logic [31:0] adr, input logic [31:0] wd,
                       output logic [31:0] rd, output bit er, output bit en,
                       output logic [2:0] sel, output int dly);
      int ec;
      bit done;
      ec = -1; done = 0; rd = '0; er = 0; en = 0; sel = '0; dly = -1;
      drive(who, 1'b1, we, adr, wd);
      for (int c = 0; c < 40 && !done; c++) begin
         @(negedge clk);
         if (m_en && ec < 0) begin ec = c; en = 1; sel = m_sel; end
         case (who)
            0: if (dbg_ack) begin done = 1; rd = dbg_di; end
            1: if (ib_ack || ib_err) begin done = 1; rd = ib_rdata; er = ib_err; end
            default: if (db_ack || db_err) begin done = 1; rd = db_rdata; er = db_err; end
         endcase
         if (done && ec >= 0) dly = c - ec;
      end
      @(posedge clk); #2;
      drop(who);
      chk("xfer_done", 32'(done), 32'd1);
   endtask

   int order[$];

   // Collect n responses; optionally release each requester once served.
   task automatic serve(input int n, input bit drop_served);
      int cnt;
      bit pend[3];
      cnt = 0;
      order.delete();
      for (int i = 0; i < 3; i++) pend[i] = 0;
      for (int c = 0; c < 200 && cnt < n; c++) begin
         @(posedge clk); #2;
         for (int i = 0; i < 3; i++) if (pend[i]) begin drop(i); pend[i] = 0; end
         @(negedge clk);
         if (dbg_ack) begin order.push_back(0); cnt++; pend[0] = drop_served; end
         if (ib_ack || ib_err) begin order.push_back(1); cnt++; pend[1] = drop_served; end
         if (db_ack || db_err) begin order.push_back(2); cnt++; pend[2] = drop_served; end
      end
      @(posedge clk); #2;
      for (int i = 0; i < 3; i++) drop(i);
      chk("serve_count", 32'(cnt), 32'(n));
   endtask

   initial begin
      #200000;
      $display("FAIL global_timeout");
      $fatal(1, "bench timeout");
   end

   initial begin
      logic [31:0] rd;
      bit er, en;
      logic [2:0] sel;
      int dly;

      n_reset = 1'b1;
      dbg_mem_op = 0; dbg_wren = 0; dbg_adr = 0; dbg_do = 0;
      ib_req = 0; ib_adr = 0;
      db_req = 0; db_we = 0; db_adr = 0; db_wdata = 0;
      #1 n_reset = 1'b0;

      // Reset state, with both CPU requests already asserted.
      drive(1, 1'b1, 4'h0, 32'h0, 32'h0);
      drive(2, 1'b1, 4'h0, 32'h4, 32'h0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_m_en", m_en, 0);
      chk("rst_m_sel", m_sel, 0);
      chk("rst_m_wren", m_wren, 0);
      chk("rst_acks", {dbg_ack, ib_ack, db_ack, ib_err, db_err}, 0);
      chk("rst_rdata", dbg_di | ib_rdata | db_rdata, 0);
      @(posedge clk); #2 n_reset = 1'b1;

      // ibus/dbus alternate, ibus first out of reset.
      serve(4, 1'b0);
      chk("rr_len", order.size(), 4);
      if (order.size() == 4) begin
         chk("rr0", order[0], 1);
         chk("rr1", order[1], 2);
         chk("rr2", order[2], 1);
         chk("rr3", order[3], 2);
      end

      // Debug write then CPU read back from RAM.
      xfer(0, 4'hF, 32'h0, 32'hAA, rd, er, en, sel, dly);
      chk("t1_wr_lat", dly, 1);
      xfer(2, 4'h0, 32'h0, 32'h0, rd, er, en, sel, dly);
      chk("t1_rd", rd, 32'hAA);
      chk("t1_sel", sel, 3'b001);
      chk("t1_lat", dly, 1);
      chk("t1_err", er, 0);

      // All three at once: debug, then ibus (dbus went last).
      drive(0, 1'b1, 4'h0, 32'h0, 32'h0);
      drive(1, 1'b1, 4'h0, 32'h0, 32'h0);
      drive(2, 1'b1, 4'h0, 32'h4, 32'h0);
      serve(3, 1'b1);
      chk("t3_len", order.size(), 3);
      if (order.size() == 3) begin
         chk("t3_o0", order[0], 0);
         chk("t3_o1", order[1], 1);
         chk("t3_o2", order[2], 2);
      end
      chk("t3_ib_rd", ib_rdata, 32'hAA);

      // ROM writes: CPU rejected, debug allowed.
      xfer(2, 4'hF, 32'h20020, 32'h12345678, rd, er, en, sel, dly);
      chk("t4_db_err", er, 1);
      chk("t4_no_en", en, 0);
      xfer(0, 4'hF, 32'h20020, 32'hCC, rd, er, en, sel, dly);
      chk("t4_dbg_en", en, 1);
      chk("t4_dbg_sel", sel, 3'b100);
      xfer(0, 4'h0, 32'h20020, 32'h0, rd, er, en, sel, dly);
      chk("t4_rom_rd", rd, 32'hCC);

      // Unmapped reads, then MMIO with extra wait cycles.
      xfer(2, 4'h0, 32'h30000, 32'h0, rd, er, en, sel, dly);
      chk("t5_3x_err", er, 1);
      chk("t5_3x_rd", rd, 0);
      xfer(2, 4'h0, 32'h40000, 32'h0, rd, er, en, sel, dly);
      chk("t5_4x_err", er, 1);
      chk("t5_4x_en", en, 0);
      xfer(0, 4'hF, 32'h10008, 32'hBB, rd, er, en, sel, dly);
      chk("t5_mmio_wr_lat", dly, 3);
      xfer(2, 4'h0, 32'h10008, 32'h0, rd, er, en, sel, dly);
      chk("t5_mmio_rd", rd, 32'hBB);
      chk("t5_mmio_sel", sel, 3'b010);
      chk("t5_mmio_lat", dly, 3);

      // Reset during the strobe cycle.
      drive(2, 1'b1, 4'h0, 32'h0, 32'h0);
      @(posedge clk); #1;
      chk("t6_en_before", m_en, 1);
      n_reset = 1'b0;
      #1;
      chk("t6_en_async", m_en, 0);
      chk("t6_sel_async", m_sel, 0);
      chk("t6_ack_async", db_ack, 0);
      chk("t6_rd_async", db_rdata, 0);
      drop(2);
      @(posedge clk); #2 n_reset = 1'b1;
      xfer(2, 4'h0, 32'h0, 32'h0, rd, er, en, sel, dly);
      chk("t6_rd", rd, 32'hAA);
      chk("t6_lat", dly, 1);

      repeat (3) @(posedge clk);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
